// File: rtl/add16_wide_sequencer.sv
// Multi-word adder sequencer: one 16-bit ripple adder, one slice per clock, LSW first.
// Carry between slices is held in a register.

module bit16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [16:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[16];
endmodule

module add16_wide_sequencer #(
  parameter int unsigned WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] sum,
  output logic                cout,
  output logic                busy
);
  localparam int unsigned W  = 16 * WORDS;
  localparam int unsigned IW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic           carry;
  logic [IW-1:0]  idx;

  logic [15:0]    sl_a;
  logic [15:0]    sl_b;
  logic [15:0]    sl_sum;
  logic           sl_cout;

  // Slice base is idx*16, formed by concatenation so the select index is exactly wide enough.
  assign sl_a = a_r[{idx, 4'b0000} +: 16];
  assign sl_b = b_r[{idx, 4'b0000} +: 16];

  bit16 u_add (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[{idx, 4'b0000} +: 16] <= sl_sum;
          carry                     <= sl_cout;
          if (idx == IW'(WORDS - 1)) begin
            cout  <= sl_cout;
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add16_wide_sequencer.sv
// Directed and randomized checks of the wide adder sequencer at WORDS=4 and WORDS=2.

module tb_add16_wide_sequencer;
  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [63:0] a, b, sum;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2, busy2;
  logic [31:0] a2, b2, sum2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  add16_wide_sequencer #(.WORDS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  add16_wide_sequencer #(.WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2), .busy(busy2)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] s;
    logic        c;
    int          hold;
  } vec_t;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One transaction on the WORDS=4 instance; hold>0 keeps out_ready low that many cycles.
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_, input logic tc,
                        input logic [63:0] es, input logic ec, input int hold);
    int lat;
    logic [63:0] rs;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = (hold == 0);
    chk("in_ready_idle", 65'(in_ready), 65'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 65'(lat), 65'd4);
    chk("sum", 65'(sum), 65'(es));
    chk("cout", 65'(cout), 65'(ec));
    chk("in_ready_done", 65'(in_ready), 65'd0);
    chk("busy_done", 65'(busy), 65'd1);
    rs = sum;
    if (hold > 0) begin
      in_valid = 1'b1; a = 64'h5555_AAAA_1234_4321; b = 64'h1; cin = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        chk("hold_stable", {cout, sum}, {ec, es});
        chk("hold_valid", 65'({out_valid, in_ready}), 65'b10);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handoff_state", 65'({out_valid, in_ready, busy}), 65'b010);
    chk("sum_retained", 65'(sum), 65'(rs));
  endtask

  // Back-to-back stream with in_valid held high and random out_ready, checked against a queue.
  task automatic stream(input int words);
    logic [64:0] exp_q[$];
    logic [64:0] ref_v, act;
    logic acc, del;
    int got, cyc;
    got = 0; cyc = 0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
    a2 = $urandom; b2 = $urandom; cin2 = 1'($urandom);
    if (words == 4) in_valid = 1'b1; else in_valid2 = 1'b1;
    while (got < 200 && cyc < 20000) begin
      @(negedge clk);
      acc = (words == 4) ? (in_valid && in_ready) : (in_valid2 && in_ready2);
      del = (words == 4) ? (out_valid && out_ready) : (out_valid2 && out_ready2);
      if (words == 4) begin
        ref_v = {1'b0, a} + {1'b0, b} + 65'(cin);
        act   = {cout, sum};
      end else begin
        ref_v = 65'({1'b0, a2} + {1'b0, b2} + 33'(cin2));
        act   = 65'({cout2, sum2});
      end
      if (del) begin
        if (exp_q.size() == 0) chk("stream_extra", 65'd1, 65'd0);
        else chk("stream_result", act, exp_q.pop_front());
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        exp_q.push_back(ref_v);
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
        a2 = $urandom; b2 = $urandom; cin2 = 1'($urandom);
      end
      out_ready  = 1'($urandom);
      out_ready2 = 1'($urandom);
    end
    in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0; out_ready2 = 1'b0;
    chk("stream_count", 65'(got), 65'd200);
    chk("stream_inflight", 65'(exp_q.size() <= 1), 65'd1);
  endtask

  vec_t vt[8];

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

    vt[0] = '{64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 1'b0, 64'h0000_0000_0000_0007, 1'b0, 0};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 1'b1, 0};
    vt[2] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0, 0};
    vt[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 10};
    vt[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 0};
    vt[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3};
    vt[6] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0001, 1'b0, 0};
    vt[7] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", 65'({in_ready, out_valid, busy}), 65'b100);
    chk("reset_result", {cout, sum}, 65'd0);
    chk("reset_flags_w2", 65'({in_ready2, out_valid2, busy2}), 65'b100);
    rst = 1'b0;

    foreach (vt[i]) run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].c, vt[i].hold);

    // Reset while idx==2: operation abandoned, reset values on the next cycle.
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("busy_mid_run", 65'(busy), 65'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_flags", 65'({in_ready, out_valid, busy}), 65'b100);
    chk("midrst_result", {cout, sum}, 65'd0);
    run_op(64'd5, 64'd6, 1'b0, 64'd11, 1'b0, 0);

    stream(4);
    stream(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
